// File: rtl/icache_direct_if.sv
//-----------------------------------------------------------------------------
// icache_direct_if
//   Bundles the two buses of the direct-mapped instruction cache:
//     - IF-stage request/response: valid, op, index, tag, offset -> addr_ok,
//       data_ok, rdata
//     - refill read port toward the AXI bridge: rd_req, rd_type, rd_addr,
//       rd_rdy, ret_valid, ret_last, ret_data
//   modport slave  : the cache's view (takes requests, issues refills)
//   modport master : the environment's view (IF stage plus bridge)
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
interface icache_direct_if #(
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
);
    localparam int TAG_W = 32 - INDEX_W - OFFSET_W;

    // IF-stage side
    logic                valid;
    logic                op;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic [OFFSET_W-1:0] offset;
    logic                addr_ok;
    logic                data_ok;
    logic [31:0]         rdata;

    // Bridge side
    logic                rd_req;
    logic [2:0]          rd_type;
    logic [31:0]         rd_addr;
    logic                rd_rdy;
    logic                ret_valid;
    logic                ret_last;
    logic [31:0]         ret_data;

    modport slave (
        input  valid, op, index, tag, offset,
        input  rd_rdy, ret_valid, ret_last, ret_data,
        output addr_ok, data_ok, rdata,
        output rd_req, rd_type, rd_addr
    );

    modport master (
        output valid, op, index, tag, offset,
        output rd_rdy, ret_valid, ret_last, ret_data,
        input  addr_ok, data_ok, rdata,
        input  rd_req, rd_type, rd_addr
    );
endinterface

// File: rtl/icache_direct.sv
//-----------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, read-only instruction cache between the IF stage and the
//   AXI bridge. 2**INDEX_W sets, each holding a valid bit, a tag and one
//   2**OFFSET_W-byte line (4 words by default). Hits return data the cycle
//   after acceptance and may be pipelined back to back; a miss refills the
//   whole line with a burst read and then re-looks-up the request.
//
// Ports:
//   clk    - clock, all state on the rising edge
//   reset  - asynchronous, active-high reset
//   bus    - icache_direct_if.slave: IF request/response and refill port
//
// Optional feature (macro ICACHE_KSEG1_BYPASS_EN):
//   Requests whose tag top three bits are 3'b101 (kseg1, 0xA0000000 -
//   0xBFFFFFFF) are uncached: forced miss, single-word read
//   (rd_type=3'b010) of the exact word, returned straight from the bridge
//   with no array update. Without the macro every address is cached.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module icache_direct #(
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    icache_direct_if.slave bus
);
    localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
    localparam int WORD_W = OFFSET_W - 2;
    localparam int SETS   = 1 << INDEX_W;
    localparam int WORDS  = 1 << WORD_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        REFILL = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Registered request (the lookup is done on these, not on the live bus)
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [WORD_W-1:0]  req_word;

    // Refill beat counter, wraps naturally at the line size
    logic [WORD_W-1:0]  beat_cnt;

    // Cache storage
    logic [SETS-1:0]    valid_bits;
    logic [TAG_W-1:0]   tag_arr  [SETS];
    logic [31:0]        data_arr [SETS][WORDS];

    // Control decode
    logic req_ok;
    logic hit;
    logic uncached;
    logic accept;
    logic beat_we;
    logic line_fill;
    logic cnt_clr;

    // Output drivers
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;

    // Byte-within-word offset bits carry no information for a word fetch.
    logic unused_offset_lsbs;
    assign unused_offset_lsbs = ^bus.offset[1:0];

    // Only reads are ever accepted; reset masks the combinational accept so
    // addr_ok is low for the whole time reset is held.
    assign req_ok = bus.valid & ~bus.op & ~reset;

`ifdef ICACHE_KSEG1_BYPASS_EN
    assign uncached = (req_tag[TAG_W-1 -: 3] == 3'b101);
`else
    assign uncached = 1'b0;
`endif

    // Uncached requests never hit, even if a stale line happens to match.
    assign hit = valid_bits[req_index] & (tag_arr[req_index] == req_tag) & ~uncached;

    //-------------------------------------------------------------------------
    // Next-state and output decode
    //-------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        rdata     = 32'h0;
        rd_req    = 1'b0;
        rd_type   = 3'b100;
        rd_addr   = 32'h0;
        accept    = 1'b0;
        beat_we   = 1'b0;
        line_fill = 1'b0;
        cnt_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                addr_ok = req_ok;
                if (req_ok) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end

            LOOKUP: begin
                if (hit) begin
                    data_ok = 1'b1;
                    rdata   = data_arr[req_index][req_word];
                    // A new request can be taken while the current hit is
                    // returned, which is what lets hits stream every cycle.
                    addr_ok = req_ok;
                    accept  = req_ok;
                    state_d = req_ok ? LOOKUP : IDLE;
                end else begin
                    state_d = MISS;
                end
            end

            MISS: begin
                rd_req = 1'b1;
                if (uncached) begin
                    rd_type = 3'b010;
                    rd_addr = {req_tag, req_index, req_word, 2'b00};
                end else begin
                    rd_type = 3'b100;
                    rd_addr = {req_tag, req_index, {OFFSET_W{1'b0}}};
                end
                if (bus.rd_rdy) begin
                    cnt_clr = 1'b1;
                    state_d = REFILL;
                end
            end

            REFILL: begin
                if (bus.ret_valid) begin
                    if (uncached) begin
                        // Single beat goes straight to the IF stage.
                        data_ok = 1'b1;
                        rdata   = bus.ret_data;
                        state_d = IDLE;
                    end else begin
                        beat_we = 1'b1;
                        if (bus.ret_last) begin
                            // Line is marked valid even on a short burst;
                            // the re-lookup then hits on the next cycle.
                            line_fill = 1'b1;
                            state_d   = LOOKUP;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    //-------------------------------------------------------------------------
    // Control state: FSM, request registers, beat counter, valid bits
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_tag    <= '0;
            req_index  <= '0;
            req_word   <= '0;
            beat_cnt   <= '0;
            valid_bits <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_tag   <= bus.tag;
                req_index <= bus.index;
                req_word  <= bus.offset[OFFSET_W-1:2];
            end
            if (cnt_clr) begin
                beat_cnt <= '0;
            end else if (beat_we) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (line_fill) begin
                valid_bits[req_index] <= 1'b1;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Tag and data arrays (contents are qualified by valid_bits, no reset)
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_arr[req_index][beat_cnt] <= bus.ret_data;
        end
        if (line_fill) begin
            tag_arr[req_index] <= req_tag;
        end
    end

    assign bus.addr_ok = addr_ok;
    assign bus.data_ok = data_ok;
    assign bus.rdata   = rdata;
    assign bus.rd_req  = rd_req;
    assign bus.rd_type = rd_type;
    assign bus.rd_addr = rd_addr;

endmodule

// File: tb/tb_icache_direct.sv
`timescale 1ns/1ps
module tb_icache_direct;

`ifdef ICACHE_KSEG1_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic reset;

    icache_direct_if #(.INDEX_W(8), .OFFSET_W(4)) bus ();

    icache_direct #(.INDEX_W(8), .OFFSET_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what each set should hold, derived from the beats
    // the bench itself delivered.
    bit          m_valid [256];
    logic [19:0] m_tag   [256];
    logic [31:0] m_data  [256][4];
    logic [31:0] fixed_beats [4];

    task automatic chk1(input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", name, obs, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk1 ({name, "_addr_ok"}, bus.addr_ok, 1'b0);
        chk1 ({name, "_data_ok"}, bus.data_ok, 1'b0);
        chk32({name, "_rdata"},   bus.rdata, 32'h0);
        chk1 ({name, "_rd_req"},  bus.rd_req, 1'b0);
        chk32({name, "_rd_type"}, 32'(bus.rd_type), 32'h4);
        chk32({name, "_rd_addr"}, bus.rd_addr, 32'h0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    endtask

    // One complete read transaction starting from IDLE, one time unit after
    // a rising edge. Expectations come from the model; the returned word is
    // handed back for extra checks against literal values.
    task automatic read_req(input logic [31:0] addr, input bit rnd, input int nbeats,
                            output logic [31:0] got);
        logic [19:0] t;
        logic [7:0]  ix;
        logic [1:0]  w;
        logic [31:0] d;
        bit          unc;
        bit          hit;
        t   = addr[31:12];
        ix  = addr[11:4];
        w   = addr[3:2];
        unc = BYPASS && (addr[31:29] == 3'b101);
        hit = !unc && m_valid[ix] && (m_tag[ix] == t);
        got = 32'h0;

        bus.valid  = 1'b1;
        bus.op     = 1'b0;
        bus.tag    = t;
        bus.index  = ix;
        bus.offset = addr[3:0];
        #1;
        chk1("addr_ok_accept", bus.addr_ok, 1'b1);
        @(posedge clk); #1;
        bus.valid = 1'b0;

        if (hit) begin
            chk1 ("hit_data_ok", bus.data_ok, 1'b1);
            chk32("hit_rdata", bus.rdata, m_data[ix][w]);
            chk1 ("hit_no_rd_req", bus.rd_req, 1'b0);
            got = bus.rdata;
        end else begin
            chk1("miss_data_ok", bus.data_ok, 1'b0);
            @(posedge clk); #1;
            chk1 ("miss_rd_req", bus.rd_req, 1'b1);
            chk32("miss_rd_type", 32'(bus.rd_type), unc ? 32'h2 : 32'h4);
            chk32("miss_rd_addr", bus.rd_addr, unc ? {addr[31:2], 2'b00} : {addr[31:4], 4'h0});
            bus.valid = 1'b1;
            #1;
            chk1("miss_no_addr_ok", bus.addr_ok, 1'b0);
            bus.valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                chk1("miss_rd_req_hold", bus.rd_req, 1'b1);
            end
            bus.rd_rdy = 1'b1;
            @(posedge clk); #1;
            bus.rd_rdy = 1'b0;
            chk1("refill_rd_req_low", bus.rd_req, 1'b0);
            if (unc) begin
                d = rnd ? $urandom : fixed_beats[0];
                bus.ret_valid = 1'b1;
                bus.ret_last  = 1'b1;
                bus.ret_data  = d;
                #1;
                chk1 ("bypass_data_ok", bus.data_ok, 1'b1);
                chk32("bypass_rdata", bus.rdata, d);
                got = bus.rdata;
                @(posedge clk); #1;
                bus.ret_valid = 1'b0;
                bus.ret_last  = 1'b0;
            end else begin
                for (int b = 0; b < nbeats; b++) begin
                    if (rnd) begin
                        repeat ($urandom_range(0, 1)) begin
                            @(posedge clk); #1;
                            chk1("refill_gap_data_ok", bus.data_ok, 1'b0);
                        end
                    end
                    d = rnd ? $urandom : fixed_beats[b];
                    bus.ret_valid = 1'b1;
                    bus.ret_last  = (b == nbeats - 1);
                    bus.ret_data  = d;
                    m_data[ix][2'(b)] = d;
                    @(posedge clk); #1;
                    bus.ret_valid = 1'b0;
                    bus.ret_last  = 1'b0;
                end
                m_valid[ix] = 1'b1;
                m_tag[ix]   = t;
                chk1 ("refill_data_ok", bus.data_ok, 1'b1);
                chk32("refill_rdata", bus.rdata, m_data[ix][w]);
                got = bus.rdata;
            end
        end
        @(posedge clk); #1;
        chk1("idle_data_ok", bus.data_ok, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] addr;

        reset         = 1'b1;
        bus.valid     = 1'b1;
        bus.op        = 1'b0;
        bus.tag       = 20'h0;
        bus.index     = 8'h0;
        bus.offset    = 4'h0;
        bus.rd_rdy    = 1'b0;
        bus.ret_valid = 1'b0;
        bus.ret_last  = 1'b0;
        bus.ret_data  = 32'h0;
        model_clear();

        // Reset state, with a request pending on the bus
        #2;
        chk_reset_outputs("reset");
        bus.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Cold miss
        fixed_beats = '{32'h11, 32'h22, 32'h33, 32'h44};
        read_req(32'h9fc00000, 1'b0, 4, got);
        chk32("cold_miss_word", got, 32'h11);

        // Hit
        read_req(32'h9fc00008, 1'b0, 4, got);
        chk32("hit_word", got, 32'h33);

        // Streaming hits
        bus.op    = 1'b0;
        bus.tag   = 20'h9fc00;
        bus.index = 8'h00;
        for (int k = 0; k < 4; k++) begin
            bus.valid  = 1'b1;
            bus.offset = 4'(k * 4);
            #1;
            chk1("stream_addr_ok", bus.addr_ok, 1'b1);
            if (k > 0) begin
                chk1 ("stream_data_ok", bus.data_ok, 1'b1);
                chk32("stream_rdata", bus.rdata, 32'h11 * (k));
            end
            @(posedge clk); #1;
        end
        bus.valid = 1'b0;
        chk1 ("stream_last_data_ok", bus.data_ok, 1'b1);
        chk32("stream_last_rdata", bus.rdata, 32'h44);
        @(posedge clk); #1;
        chk1("stream_end_data_ok", bus.data_ok, 1'b0);

        // Conflict miss on index 0, then the original line misses again
        fixed_beats = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        read_req(32'h8fc00000, 1'b0, 4, got);
        chk32("conflict_word", got, 32'hA1);
        fixed_beats = '{32'h11, 32'h22, 32'h33, 32'h44};
        read_req(32'h9fc00000, 1'b0, 4, got);
        chk32("conflict_back_word", got, 32'h11);

        // Write requests are never accepted and do nothing
        bus.valid  = 1'b1;
        bus.op     = 1'b1;
        bus.tag    = 20'h9fc00;
        bus.index  = 8'h00;
        bus.offset = 4'h0;
        #1;
        chk1("write_addr_ok", bus.addr_ok, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            chk1("write_data_ok", bus.data_ok, 1'b0);
            chk1("write_rd_req", bus.rd_req, 1'b0);
        end
        bus.valid = 1'b0;
        bus.op    = 1'b0;

        // Short burst: words beyond the last beat keep the previous line
        read_req(32'h12340060, 1'b1, 4, got);
        fixed_beats = '{32'h55, 32'h66, 32'h0, 32'h0};
        read_req(32'h56780060, 1'b0, 2, got);
        chk32("short_burst_word0", got, 32'h55);
        read_req(32'h5678006c, 1'b0, 4, got);

        // Beats outside a refill are ignored
        bus.ret_valid = 1'b1;
        bus.ret_last  = 1'b1;
        bus.ret_data  = 32'hffffffff;
        repeat (2) begin
            @(posedge clk); #1;
            chk1("stray_data_ok", bus.data_ok, 1'b0);
        end
        bus.ret_valid = 1'b0;
        bus.ret_last  = 1'b0;
        read_req(32'h56780064, 1'b0, 4, got);
        chk32("stray_word1", got, 32'h66);

        // Bypass (uncached only when the macro is set)
        fixed_beats = '{32'hdeadbeef, 32'h01, 32'h02, 32'h03};
        read_req(32'hbfc00004, 1'b0, 4, got);
        chk32("kseg1_first", got, BYPASS ? 32'hdeadbeef : 32'h01);
        fixed_beats = '{32'hcafef00d, 32'h01, 32'h02, 32'h03};
        read_req(32'hbfc00004, 1'b0, 4, got);
        chk32("kseg1_repeat", got, BYPASS ? 32'hcafef00d : 32'h01);

        // Reset in the middle of a refill
        bus.valid  = 1'b1;
        bus.op     = 1'b0;
        bus.tag    = 20'h00001;
        bus.index  = 8'h23;
        bus.offset = 4'h0;
        #1;
        chk1("mid_addr_ok", bus.addr_ok, 1'b1);
        @(posedge clk); #1;
        bus.valid = 1'b0;
        chk1("mid_miss_data_ok", bus.data_ok, 1'b0);
        @(posedge clk); #1;
        chk1("mid_rd_req", bus.rd_req, 1'b1);
        bus.rd_rdy = 1'b1;
        @(posedge clk); #1;
        bus.rd_rdy = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.ret_valid = 1'b1;
            bus.ret_data  = 32'h70 + 32'(b);
            @(posedge clk); #1;
        end
        bus.valid = 1'b1;
        reset     = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        model_clear();
        bus.valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk1("post_reset_stray_data_ok", bus.data_ok, 1'b0);
            chk1("post_reset_stray_rd_req", bus.rd_req, 1'b0);
        end
        bus.ret_valid = 1'b0;
        read_req(32'h9fc00000, 1'b1, 4, got);

        // Randomized traffic over a few tags and sets
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: addr[31:12] = 20'h9fc00;
                1: addr[31:12] = 20'h8fc00;
                2: addr[31:12] = 20'hbfc00;
                default: addr[31:12] = 20'h00400;
            endcase
            addr[11:4] = 8'($urandom_range(0, 3));
            addr[3:0]  = 4'($urandom_range(0, 15));
            read_req(addr, 1'b1, 4, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
Direct-mapped, read-only instruction cache that serves the IF stage's split request/response interface (valid/op/index/tag/offset -> addr_ok, data_ok, rdata).
- On a miss it refills one 16-byte line over a burst read port toward the AXI bridge.
- Sits between if_stage and the AXI bridge.
- Hits return data one cycle after acceptance, so back-to-back hits stream at one word per cycle.

Parameters:
- INDEX_W, 8, set-index width; 2**INDEX_W sets.
- OFFSET_W, 4, byte-offset width; line = 2**OFFSET_W bytes = 4 words; tag width = 32-INDEX_W-OFFSET_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid  in  1  IF request valid; IF holds request stable until addr_ok.
- op  in  1  0=read; 1=write (unsupported, never accepted).
- index  in  INDEX_W  set index.
- tag  in  32-INDEX_W-OFFSET_W  address tag.
- offset  in  OFFSET_W  byte offset; bits [1:0] ignored.
- addr_ok  out  1  request accepted this cycle (combinational).
- data_ok  out  1  rdata valid this cycle.
- rdata  out  32  instruction word.
- rd_req  out  1  refill read request.
- rd_type  out  3  3'b100 = line burst, 3'b010 = single word.
- rd_addr  out  32  refill start address.
- rd_rdy  in  1  bridge accepts rd_req this cycle.
- ret_valid  in  1  return beat valid.
- ret_last  in  1  final return beat.
- ret_data  in  32  return beat data.

Behaviour:
- Reset (async): state=IDLE; all line valid bits cleared; beat counter=0; request regs=0.
  - Output values during reset: addr_ok=0, data_ok=0, rdata=0, rd_req=0, rd_type=3'b100, rd_addr=0.
- Storage per set: valid bit, tag, 4x32 data words. Lookup is combinational on the registered request.
- States:
  - IDLE: addr_ok = valid & ~op. On accept, latch {tag,index,offset} -> LOOKUP.
  - LOOKUP: hit = valid_bit[req_index] & (tag_arr[req_index]==req_tag).
    - On hit: data_ok=1, rdata=data[req_index][req_offset[3:2]]; addr_ok = valid & ~op (pipelined accept). If a new request is accepted, latch it and stay in LOOKUP; else -> IDLE.
    - On miss: data_ok=0, addr_ok=0 -> MISS.
  - MISS: rd_req=1, rd_type=3'b100, rd_addr={req_tag,req_index,OFFSET_W'b0}. When rd_rdy=1 -> REFILL, beat counter=0.
  - REFILL: rd_req=0. Each ret_valid writes ret_data to data[req_index][counter] and increments the counter (2-bit, wraps).
    - On ret_valid&ret_last: write tag_arr[req_index]=req_tag, set valid bit -> LOOKUP. The re-lookup hits next cycle and returns data_ok.
- Latencies:
  - Hit: data_ok in the cycle after addr_ok.
  - Miss: rd_req the cycle after the LOOKUP miss; data_ok the cycle after the ret_last beat.
- op=1: addr_ok held 0 in every state; no state change.
- ret_valid/ret_last outside REFILL are ignored; no array write.
- Early ret_last (fewer than 4 beats): refill ends anyway. Line is marked valid; unwritten words keep old contents (bridge must not do this).
- Reset mid-refill: state returns to IDLE, all lines invalid; stray beats that follow are ignored.
- Replacement: the direct-mapped set is overwritten unconditionally (read-only, no writeback).
- addr_ok is never asserted in MISS/REFILL. IF must hold its request, and the held request is accepted in the next IDLE/LOOKUP-hit cycle.

Optional Feature:
- Macro: ICACHE_KSEG1_BYPASS_EN.
- With the macro, requests with tag[top 3 bits]==3'b101 (vaddr 0xA0000000-0xBFFFFFFF) are uncached:
  - LOOKUP forces a miss.
  - MISS issues rd_type=3'b010, rd_addr={req_tag,req_index,req_offset[OFFSET_W-1:2],2'b00}.
  - REFILL returns on the single beat: data_ok=1, rdata=ret_data, no array write -> IDLE.
- Without the macro, all addresses are cached identically.

Test Plan:
- Cold miss: reset, request 0x9fc00000 -> rd_req, rd_type=3'b100, rd_addr=0x9fc00000; rd_rdy, beats 0x11,0x22,0x33,0x44 (ret_last on 4th) -> data_ok=1, rdata=0x11 the cycle after ret_last.
- Hit: then request 0x9fc00008 -> addr_ok same cycle, data_ok next cycle with rdata=0x33, rd_req never asserted.
- Streaming hits: valid held with 0x9fc00000/04/08/0c on consecutive cycles -> addr_ok every cycle, data_ok on 4 consecutive cycles with 0x11,0x22,0x33,0x44.
- Conflict: request 0x8fc00000 (same index 0, different tag) -> miss, refill 0xA1..0xA4 returns 0xA1; then 0x9fc00000 -> misses again with rd_addr=0x9fc00000.
- Reset mid-refill: assert reset after 2 of 4 beats -> all outputs at reset values immediately; next request 0x9fc00000 misses (rd_req=1).
- Bypass (macro on): request 0xbfc00004 -> rd_type=3'b010, rd_addr=0xbfc00004; beat 0xdeadbeef -> data_ok, rdata=0xdeadbeef; repeat 0xbfc00004 -> misses again. With macro off, the same request -> rd_type=3'b100, rd_addr=0xbfc00000.
